rs232_tx_serializer: RTL and testbench
======================================

RS232_TX_SERIALIZER -- requirements
Module: rs232_tx_serializer

Interface
REQ-001 SHALL have parameter BAUD_COUNTER_WIDTH, default 9, meaning width of the baud counter.
REQ-002 SHALL have parameter BAUD_TICK_INCREMENT, default 9'd1, meaning counter step per clock.
REQ-003 SHALL have parameter BAUD_TICK_COUNT, default 9'd435, meaning counter value that defines one bit period.
REQ-004 SHALL have parameter HALF_BAUD_TICK_COUNT, default 9'd218, meaning accepted for parameter compatibility and unused in TX.
REQ-005 SHALL have parameter TOTAL_DATA_WIDTH, default 11, meaning bits per frame: start + data + stop.
REQ-006 SHALL have parameter DATA_WIDTH, default 9, meaning payload bits per frame (8 data + parity).
REQ-007 SHALL have port clk, input, 1, meaning the single clock.
REQ-008 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-009 SHALL have port transmit_data, input, DATA_WIDTH, meaning word to queue; bit 0 is sent first.
REQ-010 SHALL have port transmit_data_en, input, 1, meaning one-cycle write strobe for transmit_data.
REQ-011 SHALL have port fifo_write_space, output, 8, meaning free FIFO entries (0..128), registered.
REQ-012 SHALL have port serial_data_out, output, 1, meaning UART TX line, registered, idle high.

Function
REQ-013 SHALL buffer words in a 128-entry FIFO, DATA_WIDTH bits wide.
REQ-014 SHALL write transmit_data into the FIFO on a clk edge with transmit_data_en=1 and FIFO not full; fifo_write_space SHALL reflect the write on the next cycle.
REQ-015 SHALL silently drop a write while the FIFO is full; FIFO contents unchanged, fifo_write_space stays 0.
REQ-016 SHALL leave fifo_write_space unchanged when a write and a pop occur in the same cycle; a write to a full FIFO in a pop cycle SHALL be accepted.
REQ-017 SHALL implement states IDLE and SHIFT; IDLE->SHIFT when the FIFO is non-empty; SHIFT->IDLE after the last stop-bit cycle if the FIFO is empty.
REQ-018 SHALL, on IDLE->SHIFT, pop the head word and load the shift register with {1'b1, word, 1'b0}, TOTAL_DATA_WIDTH bits.
REQ-019 SHALL drive serial_data_out low (start bit) in the cycle after the one in which the FIFO is seen non-empty in IDLE.
REQ-020 SHALL send each frame LSB first: start 0, transmit_data[0]..[DATA_WIDTH-1], stop 1.
REQ-021 SHALL hold each bit for exactly BAUD_TICK_COUNT cycles at BAUD_TICK_INCREMENT=1; the counter advances by BAUD_TICK_INCREMENT per SHIFT cycle, ticks at BAUD_TICK_COUNT-BAUD_TICK_INCREMENT, then clears to 0.
REQ-022 SHALL clear the baud counter to 0 at every frame load.
REQ-023 SHALL start the next frame back-to-back: if the FIFO is non-empty at the end of the last stop-bit cycle, pop and load in that cycle, and drive the start bit in the next cycle with no idle gap.
REQ-024 SHALL hold serial_data_out at 1 in IDLE.
REQ-025 SHALL use modulo-128 wrap-around for FIFO read and write pointers, with a separate full/empty indication; no pointer overflow SHALL corrupt data.

Reset
REQ-026 SHALL, on reset=1 at a clk edge, set serial_data_out=1, fifo_write_space=8'd128, state IDLE, baud counter 0, FIFO empty.
REQ-027 SHALL, on reset mid-frame, abort the frame; line high the next cycle and queued words discarded.
REQ-028 SHALL give reset priority over a simultaneous transmit_data_en; the word is not stored.

Verification
REQ-029 SHALL cover: assert reset, then idle -> serial_data_out=1 and fifo_write_space=128 constant.
REQ-030 SHALL cover: write 9'h055 once -> line shows 0,1,0,1,0,1,0,1,0,0,1, each bit for 435 cycles, 4785 cycles total, then idle high; space 127 for 1 cycle, then 128.
REQ-031 SHALL cover: write 9'h1A5 then 9'h0FF in consecutive cycles -> second start bit begins the cycle after the first stop bit ends, with no high gap.
REQ-032 SHALL cover: 130 writes on consecutive cycles from empty -> the first word is popped into the shifter, 128 are queued, the 130th is dropped, space=0; then drain by popping and check order.
REQ-033 SHALL cover: write during the pop cycle of the next frame with space=0 -> word is accepted and space stays 0.
REQ-034 SHALL cover: reset during data bit 4 with 5 words queued -> line=1 next cycle, space=128, and no further frames.

Source files
------------

// File: rtl/rs232_tx_serializer.sv
// -----------------------------------------------------------------------------
// rs232_tx_serializer
//
// Purpose:
//   UART transmitter with a 128-entry write FIFO. Words written through
//   transmit_data/transmit_data_en are queued and sent LSB first as
//   start(0) + DATA_WIDTH payload bits + stop(1), one bit per baud period.
//   Frames are sent back-to-back while the FIFO holds data.
//
// Ports:
//   clk              - single clock
//   reset            - synchronous active-high reset
//   transmit_data    - word to queue; bit 0 goes out first
//   transmit_data_en - one-cycle write strobe for transmit_data
//   fifo_write_space - free FIFO entries (0..128), registered
//   serial_data_out  - UART TX line, registered, idle high
// -----------------------------------------------------------------------------
module rs232_tx_serializer #(
   parameter int unsigned                   BAUD_COUNTER_WIDTH   = 9,
   parameter logic [BAUD_COUNTER_WIDTH-1:0] BAUD_TICK_INCREMENT  = 9'd1,
   parameter logic [BAUD_COUNTER_WIDTH-1:0] BAUD_TICK_COUNT      = 9'd435,
   parameter logic [BAUD_COUNTER_WIDTH-1:0] HALF_BAUD_TICK_COUNT = 9'd218,
   parameter int unsigned                   TOTAL_DATA_WIDTH     = 11,
   parameter int unsigned                   DATA_WIDTH           = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] transmit_data,
   input  logic                  transmit_data_en,
   output logic [7:0]            fifo_write_space,
   output logic                  serial_data_out
);

   localparam int unsigned FIFO_DEPTH = 128;
   localparam int unsigned PTR_W      = 7;
   localparam int unsigned BIT_CNT_W  = $clog2(TOTAL_DATA_WIDTH);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(TOTAL_DATA_WIDTH - 1);
   localparam logic [7:0] SPACE_EMPTY = 8'd128;

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } state_e;

   // Receive-side compatibility parameter; kept so both directions share one
   // parameter set, but the transmitter never samples mid-bit.
   logic [BAUD_COUNTER_WIDTH-1:0] unused_half_tick;
   assign unused_half_tick = HALF_BAUD_TICK_COUNT;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e                        state_q,    state_d;
   logic [BAUD_COUNTER_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
   logic [BIT_CNT_W-1:0]          bit_cnt_q,  bit_cnt_d;
   logic [TOTAL_DATA_WIDTH-1:0]   shift_q,    shift_d;
   logic                          serial_q,   serial_d;
   logic [PTR_W-1:0]              wr_ptr_q,   wr_ptr_d;
   logic [PTR_W-1:0]              rd_ptr_q,   rd_ptr_d;
   logic [7:0]                    space_q,    space_d;

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  push;
   logic                  pop;
   logic                  baud_tick;
   logic                  last_bit;
   logic [DATA_WIDTH-1:0] fifo_rd_data;

   // The free-space count doubles as the full/empty flag, so the 7-bit
   // pointers may wrap freely without ambiguity when they are equal.
   assign fifo_empty   = (space_q == SPACE_EMPTY);
   assign fifo_full    = (space_q == 8'd0);
   assign fifo_rd_data = mem_q[rd_ptr_q];

   assign baud_tick = (baud_cnt_q == (BAUD_TICK_COUNT - BAUD_TICK_INCREMENT));
   assign last_bit  = (bit_cnt_q == LAST_BIT);

   // A full FIFO still accepts a write in the cycle its head is popped: the
   // slot being read this cycle is the one the write lands in at the edge.
   assign push = transmit_data_en && (!fifo_full || pop);

   // ---------------------------------------------------------------------------
   // FSM next-state / datapath
   // ---------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default before the case statement;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      serial_d   = serial_q;
      pop        = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            serial_d   = 1'b1;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            if (!fifo_empty) begin
               pop        = 1'b1;
               state_d    = ST_SHIFT;
               shift_d    = {1'b1, fifo_rd_data, 1'b0};
               serial_d   = 1'b0;
            end
         end

         ST_SHIFT: begin
            if (!baud_tick) begin
               baud_cnt_d = baud_cnt_q + BAUD_TICK_INCREMENT;
            end else begin
               baud_cnt_d = '0;
               if (!last_bit) begin
                  shift_d   = shift_q >> 1;
                  serial_d  = shift_q[1];
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end else if (!fifo_empty) begin
                  // End of stop bit with more data: reload in this cycle so
                  // the next start bit follows with no idle gap.
                  pop       = 1'b1;
                  shift_d   = {1'b1, fifo_rd_data, 1'b0};
                  serial_d  = 1'b0;
                  bit_cnt_d = '0;
               end else begin
                  state_d   = ST_IDLE;
                  serial_d  = 1'b1;
                  bit_cnt_d = '0;
               end
            end
         end

         default: begin
            state_d  = ST_IDLE;
            serial_d = 1'b1;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // FIFO pointer / occupancy next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      space_d  = space_q;
      unique case ({push, pop})
         2'b10:   space_d = space_q - 8'd1;
         2'b01:   space_d = space_q + 8'd1;
         default: space_d = space_q;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '1;
         serial_q   <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         space_q    <= SPACE_EMPTY;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         serial_q   <= serial_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         space_q    <= space_d;
      end
   end

   // NOTE: the storage array has no reset; resetting the pointers and the
   // space count empties the FIFO, and stale contents are never read.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem_q[wr_ptr_q] <= transmit_data;
      end
   end

   assign fifo_write_space = space_q;
   assign serial_data_out  = serial_q;

endmodule

// File: tb/tb_rs232_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_rs232_tx_serializer
//
// Two instances share the clock: dut_s with default parameters (435-cycle
// bits) and dut_f with increment 2 / count 32 (16-cycle bits) for the long
// fill-and-drain sequence. Inputs change 1 time unit after posedge; outputs
// are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_rs232_tx_serializer;

   localparam int SLOW_BIT = 435;
   localparam int FAST_BIT = 16;

   logic       clk;
   logic       reset_s, en_s, line_s;
   logic [8:0] data_s;
   logic [7:0] space_s;
   logic       reset_f, en_f, line_f;
   logic [8:0] data_f;
   logic [7:0] space_f;

   int checks   = 0;
   int failures = 0;

   logic [8:0] wv [0:130];

   rs232_tx_serializer dut_s (
      .clk              (clk),
      .reset            (reset_s),
      .transmit_data    (data_s),
      .transmit_data_en (en_s),
      .fifo_write_space (space_s),
      .serial_data_out  (line_s)
   );

   rs232_tx_serializer #(
      .BAUD_TICK_INCREMENT (9'd2),
      .BAUD_TICK_COUNT     (9'd32)
   ) dut_f (
      .clk              (clk),
      .reset            (reset_f),
      .transmit_data    (data_f),
      .transmit_data_en (en_f),
      .fifo_write_space (space_f),
      .serial_data_out  (line_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at the negedge of the first start-bit cycle; returns at the
   // negedge of the cycle right after the stop bit.
   task automatic expect_frame(input bit fast, input logic [8:0] w, input string tag);
      logic [10:0] frame;
      int          period;
      int          hits;
      frame  = {1'b1, w, 1'b0};
      period = fast ? FAST_BIT : SLOW_BIT;
      for (int b = 0; b < 11; b++) begin
         hits = 0;
         for (int c = 0; c < period; c++) begin
            if ((fast ? line_f : line_s) === frame[b]) hits++;
            @(negedge clk);
         end
         check($sformatf("%s_bit%0d", tag, b), hits, period);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int hi_s, hi_f, sp_s, sp_f, lows;

      reset_s = 1'b1; en_s = 1'b0; data_s = '0;
      reset_f = 1'b1; en_f = 1'b0; data_f = '0;
      for (int i = 0; i < 130; i++) wv[i] = 9'((i * 37 + 5) % 512);
      wv[130] = 9'h1C3;

      repeat (3) @(posedge clk);
      #1 reset_s = 1'b0; reset_f = 1'b0;

      // ---- Idle after reset ----
      hi_s = 0; hi_f = 0; sp_s = 0; sp_f = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (line_s === 1'b1) hi_s++;
         if (line_f === 1'b1) hi_f++;
         if (space_s === 8'd128) sp_s++;
         if (space_f === 8'd128) sp_f++;
      end
      check("idle_line_s", hi_s, 50);
      check("idle_line_f", hi_f, 50);
      check("idle_space_s", sp_s, 50);
      check("idle_space_f", sp_f, 50);

      // ---- Single word 9'h055 ----
      @(posedge clk); #1 en_s = 1'b1; data_s = 9'h055;
      @(posedge clk); #1 en_s = 1'b0;
      @(negedge clk);
      check("w055_space_after_write", space_s, 127);
      check("w055_line_before_start", line_s, 1);
      @(negedge clk);
      check("w055_space_after_pop", space_s, 128);
      check("w055_start_latency", line_s, 0);
      expect_frame(1'b0, 9'h055, "w055");
      check("w055_idle_after", line_s, 1);
      check("w055_space_end", space_s, 128);

      // ---- Back-to-back 9'h1A5, 9'h0FF ----
      @(posedge clk); #1 en_s = 1'b1; data_s = 9'h1A5;
      @(posedge clk); #1 data_s = 9'h0FF;
      @(posedge clk); #1 en_s = 1'b0;
      @(negedge clk);
      check("b2b_space_push_pop", space_s, 127);
      check("b2b_start", line_s, 0);
      expect_frame(1'b0, 9'h1A5, "b2b_1A5");
      expect_frame(1'b0, 9'h0FF, "b2b_0FF");
      check("b2b_idle_after", line_s, 1);
      check("b2b_space_end", space_s, 128);

      // ---- 130 consecutive writes into the fast instance ----
      @(posedge clk); #1 en_f = 1'b1; data_f = wv[0];
      for (int i = 1; i < 130; i++) begin
         @(posedge clk); #1 data_f = wv[i];
         if (i == 2) begin
            @(negedge clk);
            check("fill_space_after_first_pop", space_f, 127);
         end
         if (i == 129) begin
            @(negedge clk);
            check("fill_space_full", space_f, 0);
         end
      end
      @(posedge clk); #1 en_f = 1'b0;
      @(negedge clk);
      check("fill_space_after_drop", space_f, 0);
      check("fill_line_w0_running", line_f, 0);

      // ---- Write while full in the pop cycle of the next frame ----
      repeat (47) @(posedge clk);
      #1 en_f = 1'b1; data_f = wv[130];
      @(posedge clk); #1 en_f = 1'b0;
      @(negedge clk);
      check("full_pop_write_space", space_f, 0);
      for (int i = 1; i < 129; i++) expect_frame(1'b1, wv[i], $sformatf("drain%0d", i));
      expect_frame(1'b1, wv[130], "drain_late");
      check("drain_idle_after", line_f, 1);
      check("drain_space_end", space_f, 128);

      // ---- Reset during data bit 4 with 5 words queued ----
      @(posedge clk); #1 en_s = 1'b1; data_s = 9'h0E5;
      for (int i = 1; i < 6; i++) begin
         @(posedge clk); #1 data_s = 9'h100 + 9'(i);
      end
      @(posedge clk); #1 en_s = 1'b0;
      @(negedge clk);
      check("rst_space_queued", space_s, 123);
      repeat (2370) @(posedge clk);
      @(negedge clk);
      check("rst_line_data_bit4", line_s, 0);
      @(posedge clk); #1 reset_s = 1'b1; en_s = 1'b1; data_s = 9'h1FF;
      @(posedge clk); #1 reset_s = 1'b0; en_s = 1'b0;
      @(negedge clk);
      check("rst_line_high", line_s, 1);
      check("rst_space_128", space_s, 128);
      lows = 0; sp_s = 0;
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         if (line_s !== 1'b1) lows++;
         if (space_s === 8'd128) sp_s++;
      end
      check("rst_no_frames", lows, 0);
      check("rst_space_stays", sp_s, 5000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
